alu: RTL and testbench



---
 rtl/alu.sv | 131 +++++++++++++
 tb/tb_alu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- registered arithmetic/logic unit for the datapath execute stage.
//
// One of eight operations is applied to two WIDTH-bit operands, chosen by a
// 3-bit opcode. The result and three status flags are captured on the rising
// clock edge. Operands and opcode arrive from decode, and alu_out feeds
// writeback.
//
// Timing: inputs sampled at edge N are visible on the outputs after edge N.
// The unit accepts a new operation every cycle. It has no valid/ready
// handshake and never stalls: every clock edge is one transaction, and the
// outputs hold their value between edges.
//
// Ports:
//   clk         in   1      system clock; all state updates on the rising edge
//   rst         in   1      synchronous, active-high reset (wins over opcode)
//   opperand_1  in   WIDTH  operand A
//   opperand_2  in   WIDTH  operand B
//   opcode      in   3      operation select (all eight codes defined)
//   alu_out     out  WIDTH  registered result
//   carry_out   out  1      registered carry / borrow / shifted-out bit
//   zero        out  1      registered: 1 when the result is all zeros
//   overflow    out  1      registered signed overflow (ADD/SUB only)
//
// Opcodes:
//   000 ADD   001 SUB   010 AND   011 OR
//   100 XOR   101 NOT   110 SHL   111 SHR
// -----------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] opperand_1,
  input  logic [WIDTH-1:0] opperand_2,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] alu_out,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Extended-width sum and difference. The extra top bit of w_sum is the
  // carry out of the addition. In w_diff the extra bit is the borrow: it is
  // set exactly when A < B as unsigned numbers.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_overflow;
  logic             w_zero;

  logic [WIDTH-1:0] r_alu_out;
  logic             r_carry;
  logic             r_zero;
  logic             r_overflow;

  assign w_sum  = {1'b0, opperand_1} + {1'b0, opperand_2};
  assign w_diff = {1'b0, opperand_1} - {1'b0, opperand_2};

  always_comb begin
    w_result   = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_result   = w_sum[WIDTH-1:0];
        w_carry    = w_sum[WIDTH];
        // Operands share a sign, but the result sign differs from it.
        w_overflow = (opperand_1[WIDTH-1] == opperand_2[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != opperand_1[WIDTH-1]);
      end
      OP_SUB: begin
        w_result   = w_diff[WIDTH-1:0];
        w_carry    = w_diff[WIDTH];
        // Operand signs differ, and the result sign differs from A.
        w_overflow = (opperand_1[WIDTH-1] != opperand_2[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != opperand_1[WIDTH-1]);
      end
      OP_AND: w_result = opperand_1 & opperand_2;
      OP_OR:  w_result = opperand_1 | opperand_2;
      OP_XOR: w_result = opperand_1 ^ opperand_2;
      OP_NOT: w_result = ~opperand_1;
      OP_SHL: begin
        w_result = {opperand_1[WIDTH-2:0], 1'b0};
        w_carry  = opperand_1[WIDTH-1];
      end
      OP_SHR: begin
        w_result = {1'b0, opperand_1[WIDTH-1:1]};
        w_carry  = opperand_1[0];
      end
      default: begin
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
      end
    endcase
  end

  assign w_zero = (w_result == '0);

  // The reset state reports a zero result, so the zero flag is set in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_out  <= '0;
      r_carry    <= 1'b0;
      r_zero     <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_alu_out  <= w_result;
      r_carry    <= w_carry;
      r_zero     <= w_zero;
      r_overflow <= w_overflow;
    end
  end

  assign alu_out   = r_alu_out;
  assign carry_out = r_carry;
  assign zero      = r_zero;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
//
// Each transaction is driven on the falling edge. Its expected outputs are
// pushed onto exp_q at that moment. On the next falling edge, one rising edge
// later, the entry is popped and compared with the DUT outputs.
//
// Each queue entry is packed as {overflow, zero, carry, result}.
// -----------------------------------------------------------------------------
module tb_alu;

  localparam int WIDTH = 8;
  localparam int W     = WIDTH + 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] opperand_1;
  logic [WIDTH-1:0] opperand_2;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] alu_out;
  logic             carry_out;
  logic             zero;
  logic             overflow;

  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_errors;

  alu #(.WIDTH(WIDTH)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .opperand_1 (opperand_1),
    .opperand_2 (opperand_2),
    .opcode     (opcode),
    .alu_out    (alu_out),
    .carry_out  (carry_out),
    .zero       (zero),
    .overflow   (overflow)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Check task
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] model(input logic [2:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    int unsigned      ua;
    int unsigned      ub;
    int unsigned      full;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    ua = a;
    ub = b;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      OP_ADD: begin
        full = ua + ub;
        res  = full[WIDTH-1:0];
        c    = (full > 255);
        v    = (a[7] == b[7]) && (res[7] != a[7]);
      end
      OP_SUB: begin
        res = WIDTH'((ua + 256) - ub);
        c   = (ua < ub);
        v   = (a[7] != b[7]) && (res[7] != a[7]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: begin
        res = WIDTH'(ua * 2);
        c   = a[7];
      end
      default: begin
        res = WIDTH'(ua / 2);
        c   = a[0];
      end
    endcase
    return {v, (res == 0), c, res};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard pop/compare
  // ---------------------------------------------------------------------------
  task automatic compare_pending(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, ".res"},  32'(alu_out),   32'(e[WIDTH-1:0]));
      check({tag, ".c"},    32'(carry_out), 32'(e[WIDTH]));
      check({tag, ".zero"}, 32'(zero),      32'(e[WIDTH+1]));
      check({tag, ".ovf"},  32'(overflow),  32'(e[WIDTH+2]));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  // Directed vector with a fixed expectation.
  // If r is set, the expectation is the reset state.
  task automatic drive_vec(input string tag, input logic r,
                           input logic [2:0] op,
                           input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] e_res,
                           input logic e_c, input logic e_z, input logic e_v);
    @(negedge clk);
    compare_pending(tag);
    rst        = r;
    opcode     = op;
    opperand_1 = a;
    opperand_2 = b;
    exp_q.push_back({e_v, e_z, e_c, e_res});
  endtask

  // Vector whose expectation comes from the reference model.
  task automatic drive_model(input string tag, input logic [2:0] op,
                             input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b);
    @(negedge clk);
    compare_pending(tag);
    rst        = 1'b0;
    opcode     = op;
    opperand_1 = a;
    opperand_2 = b;
    exp_q.push_back(model(op, a, b));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    opcode     = OP_ADD;
    opperand_1 = 8'h12;
    opperand_2 = 8'h34;

    // Reset holds priority even with a non-zero operation on the inputs.
    drive_vec("reset",  1'b1, OP_ADD, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b0);

    // A=3, B=1 across the first four opcodes, driven back to back.
    drive_vec("add31",  1'b0, OP_ADD, 8'd3,  8'd1,  8'd4,  1'b0, 1'b0, 1'b0);
    drive_vec("sub31",  1'b0, OP_SUB, 8'd3,  8'd1,  8'd2,  1'b0, 1'b0, 1'b0);
    drive_vec("and31",  1'b0, OP_AND, 8'd3,  8'd1,  8'd1,  1'b0, 1'b0, 1'b0);
    drive_vec("or31",   1'b0, OP_OR,  8'd3,  8'd1,  8'd3,  1'b0, 1'b0, 1'b0);

    // Boundary cases.
    drive_vec("addwrap", 1'b0, OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    drive_vec("addovf",  1'b0, OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    drive_vec("subwrap", 1'b0, OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
    drive_vec("subovf",  1'b0, OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
    drive_vec("xor",     1'b0, OP_XOR, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0);
    drive_vec("not",     1'b0, OP_NOT, 8'hF0, 8'h33, 8'h0F, 1'b0, 1'b0, 1'b0);
    drive_vec("shl",     1'b0, OP_SHL, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
    drive_vec("shr",     1'b0, OP_SHR, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0);

    // Reset pulsed mid-stream: that edge clears the outputs.
    // The next edge produces a fresh result.
    drive_vec("midrst",  1'b1, OP_OR,  8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    drive_vec("postrst", 1'b0, OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    drive_vec("subeq",   1'b0, OP_SUB, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0);

    // Random back-to-back traffic, with expectations from the reference model.
    for (int i = 0; i < 60; i++) begin
      drive_model("rand", 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // Drain the final outstanding expectation.
    @(negedge clk);
    compare_pending("drain");
    check("q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
